// File: rtl/data_cache_port_pkg.sv
// Shared widths and FSM state encoding for the data-space cache port.
`timescale 1ns/1ps
package data_cache_port_pkg;

  localparam int ADDR_W  = 10;
  localparam int PAGE_W  = 7;
  localparam int DATA_W  = 16;
  localparam int IDX_W   = 6;
  localparam int LINES   = 1 << IDX_W;
  localparam int TAG_W   = PAGE_W + ADDR_W - IDX_W;
  localparam int PADDR_W = PAGE_W + ADDR_W;

  typedef enum logic [3:0] {
    IDLE, LOOKUP, WB, FILL, DONE, WAIT_REL, FL_RD, FL_CHK, FL_WB, FL_NEXT
  } state_e;

endpackage

// File: rtl/data_cache_port_if.sv
// CPU-side p2 request bus plus physical memory bus of the data cache port.
`timescale 1ns/1ps
interface data_cache_port_if;
  import data_cache_port_pkg::*;

  // p2 handshake: p2_req is held (with wren/addr/wdata stable) until the
  // one-cycle p2_ready pulse; mem_req is likewise held until one-cycle mem_ready.
  logic                p2_reset;
  logic                p2_flush;
  logic [PAGE_W-1:0]   p2_page;
  logic                p2_req;
  logic                p2_wren;
  logic [ADDR_W-1:0]   p2_addr;
  logic [DATA_W-1:0]   p2_wdata;
  logic [DATA_W-1:0]   p2_rdata;
  logic                p2_ready;
  logic                mem_req;
  logic                mem_wren;
  logic [PADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ready;

  modport slave (
    input  p2_reset, p2_flush, p2_page, p2_req, p2_wren, p2_addr, p2_wdata,
    input  mem_rdata, mem_ready,
    output p2_rdata, p2_ready, mem_req, mem_wren, mem_addr, mem_wdata
  );

  modport master (
    output p2_reset, p2_flush, p2_page, p2_req, p2_wren, p2_addr, p2_wdata,
    output mem_rdata, mem_ready,
    input  p2_rdata, p2_ready, mem_req, mem_wren, mem_addr, mem_wdata
  );

endinterface

// File: rtl/data_cache_port_line_ram.sv
// Tag+data line store: one write port, one synchronous read port (1-cycle latency).
`timescale 1ns/1ps
module cache_line_ram
  import data_cache_port_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [TAG_W-1:0]  rtag_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [TAG_W+DATA_W-1:0] mem_q [LINES];
  logic [TAG_W+DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= {wtag_i, wdata_i};
    rd_q <= mem_q[raddr_i];
  end

  assign {rtag_o, rdata_o} = rd_q;

endmodule

// File: rtl/data_cache_port.sv
// Direct-mapped, write-back, write-allocate one-word-line cache on the p2 data port.
`timescale 1ns/1ps
module data_cache_port
  import data_cache_port_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  data_cache_port_if.slave bus,
  output logic   busy,
  output state_e state_o
);

  state_e              state_q, state_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wren_q, wren_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [LINES-1:0]    valid_q, valid_d, dirty_q, dirty_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_req_q, mem_req_d, mem_wren_q, mem_wren_d;
  logic [PADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]    idx, ram_raddr;
  logic [TAG_W-1:0]    cur_tag, ram_rtag;
  logic [DATA_W-1:0]   ram_rdata, ram_wdata;
  logic [PADDR_W-1:0]  phys;
  logic                ram_we, hit;

  assign idx     = addr_q[IDX_W-1:0];
  assign cur_tag = {page_q, addr_q[ADDR_W-1:IDX_W]};
  assign phys    = {page_q, addr_q};
  assign hit     = valid_q[idx] && (ram_rtag == cur_tag);
  // In IDLE the RAM is addressed straight from the bus so LOOKUP sees the line.
  assign ram_raddr = (state_q == IDLE) ? bus.p2_addr[IDX_W-1:0] : cnt_q;

  cache_line_ram u_ram (
    .clk     (clk),
    .we_i    (ram_we && !rst && !bus.p2_reset),
    .waddr_i (idx),
    .wtag_i  (cur_tag),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rtag_o  (ram_rtag),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;   page_d = page_q;     addr_d = addr_q;
    wren_d = wren_q;     wdata_d = wdata_q;   cnt_d = cnt_q;
    valid_d = valid_q;   dirty_d = dirty_q;   rdata_d = rdata_q;
    mem_req_d = mem_req_q;   mem_wren_d = mem_wren_q;
    mem_addr_d = mem_addr_q; mem_wdata_d = mem_wdata_q;
    ram_we = 1'b0;       ram_wdata = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.p2_flush) begin
          cnt_d = '0;
          state_d = FL_RD;
        end else if (bus.p2_req) begin
          page_d = bus.p2_page;  addr_d = bus.p2_addr;
          wren_d = bus.p2_wren;  wdata_d = bus.p2_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          if (wren_q) begin
            ram_we = 1'b1;
            dirty_d[idx] = 1'b1;
          end else begin
            rdata_d = ram_rdata;
          end
          state_d = DONE;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          mem_req_d = 1'b1;  mem_wren_d = 1'b1;
          mem_addr_d = {ram_rtag, idx};  mem_wdata_d = ram_rdata;
          state_d = WB;
        end else if (wren_q) begin
          ram_we = 1'b1;
          valid_d[idx] = 1'b1;  dirty_d[idx] = 1'b1;
          state_d = DONE;
        end else begin
          mem_req_d = 1'b1;  mem_wren_d = 1'b0;  mem_addr_d = phys;
          state_d = FILL;
        end
      end
      WB: if (bus.mem_ready) begin
        dirty_d[idx] = 1'b0;
        if (wren_q) begin
          ram_we = 1'b1;
          valid_d[idx] = 1'b1;  dirty_d[idx] = 1'b1;
          mem_req_d = 1'b0;  mem_wren_d = 1'b0;
          state_d = DONE;
        end else begin
          mem_req_d = 1'b1;  mem_wren_d = 1'b0;  mem_addr_d = phys;
          state_d = FILL;
        end
      end
      FILL: if (bus.mem_ready) begin
        ram_we = 1'b1;  ram_wdata = bus.mem_rdata;
        valid_d[idx] = 1'b1;  dirty_d[idx] = 1'b0;
        rdata_d = bus.mem_rdata;
        mem_req_d = 1'b0;
        state_d = DONE;
      end
      DONE:     state_d = WAIT_REL;
      WAIT_REL: if (!bus.p2_req) state_d = IDLE;
      FL_RD:    state_d = FL_CHK;
      FL_CHK: begin
        if (valid_q[cnt_q] && dirty_q[cnt_q]) begin
          mem_req_d = 1'b1;  mem_wren_d = 1'b1;
          mem_addr_d = {ram_rtag, cnt_q};  mem_wdata_d = ram_rdata;
          state_d = FL_WB;
        end else begin
          valid_d[cnt_q] = 1'b0;
          state_d = FL_NEXT;
        end
      end
      FL_WB: if (bus.mem_ready) begin
        valid_d[cnt_q] = 1'b0;  dirty_d[cnt_q] = 1'b0;
        mem_req_d = 1'b0;  mem_wren_d = 1'b0;
        state_d = FL_NEXT;
      end
      FL_NEXT: begin
        if (cnt_q == IDX_W'(LINES - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          state_d = FL_RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The soft reset aborts any operation, dropping mem_req and dirty data.
  always_ff @(posedge clk) begin
    if (rst || bus.p2_reset) begin
      state_q <= IDLE;  page_q <= '0;  addr_q <= '0;  wren_q <= 1'b0;
      wdata_q <= '0;    cnt_q <= '0;   valid_q <= '0; dirty_q <= '0;
      rdata_q <= '0;    mem_req_q <= 1'b0;  mem_wren_q <= 1'b0;
      mem_addr_q <= '0; mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;  page_q <= page_d;  addr_q <= addr_d;  wren_q <= wren_d;
      wdata_q <= wdata_d;  cnt_q <= cnt_d;    valid_q <= valid_d; dirty_q <= dirty_d;
      rdata_q <= rdata_d;  mem_req_q <= mem_req_d;  mem_wren_q <= mem_wren_d;
      mem_addr_q <= mem_addr_d;  mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.p2_ready  = (state_q == DONE);
  assign bus.p2_rdata  = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wren  = mem_wren_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state_q != IDLE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_data_cache_port.sv
// Directed bench for data_cache_port with a two-cycle backing-memory responder.
`timescale 1ns/1ps
module tb_data_cache_port;
  import data_cache_port_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   busy;
  state_e state_o;

  data_cache_port_if bus();

  data_cache_port dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .busy    (busy),
    .state_o (state_o)
  );

  // clock/reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // mem transaction record: {wren, addr[16:0], data[15:0]}
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  logic [15:0] bmem [int];

  function automatic logic [15:0] pat(input logic [16:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // backing memory: ready two cycles after it first sees mem_req
  initial begin : mem_model
    int          wait_cnt;
    logic [15:0] d;
    wait_cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (bus.mem_req && !rst) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          wait_cnt = 0;
          bus.mem_ready = 1'b1;
          if (bus.mem_wren) begin
            bmem[int'(bus.mem_addr)] = bus.mem_wdata;
            obs_q.push_back({1'b1, bus.mem_addr, bus.mem_wdata});
          end else begin
            d = bmem.exists(int'(bus.mem_addr)) ? bmem[int'(bus.mem_addr)] : pat(bus.mem_addr);
            bus.mem_rdata = d;
            obs_q.push_back({1'b0, bus.mem_addr, d});
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic sb_begin();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic sb_check(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, obs_q[i], exp_q[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  // driver: one request, optionally raised together with a flush pulse
  task automatic access(input logic [6:0] page, input logic [9:0] addr, input logic wren,
                        input logic [15:0] wdata, input bit with_flush, input int hold,
                        output logic [15:0] rdata, output int lat, output int pulses);
    bit seen;
    seen = 0; lat = 0; pulses = 0; rdata = '0;
    @(negedge clk);
    bus.p2_page = page;  bus.p2_addr = addr;
    bus.p2_wren = wren;  bus.p2_wdata = wdata;
    bus.p2_req = 1'b1;
    if (with_flush) begin
      bus.p2_flush = 1'b1;
      @(negedge clk);
      bus.p2_flush = 1'b0;
    end
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.p2_ready) begin
        seen = 1;
        rdata = bus.p2_rdata;
        pulses++;
      end
    end
    chk("ready_seen", seen, 1);
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.p2_ready) pulses++;
    end
    @(negedge clk);
    bus.p2_req = 1'b0;
    wait_idle();
  endtask

  task automatic flush(output int busy_cycles);
    @(negedge clk);
    bus.p2_flush = 1'b1;
    @(negedge clk);
    bus.p2_flush = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 5000) begin
      @(posedge clk); #1;
      busy_cycles++;
    end
    chk("flush_idle", busy, 0);
  endtask

  task automatic soft_reset();
    @(negedge clk);
    bus.p2_reset = 1'b1;
    @(negedge clk);
    bus.p2_reset = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] rd;
    int lat, pul, bc;
    rst = 1'b1;
    bus.p2_reset = 1'b0;  bus.p2_flush = 1'b0;  bus.p2_page = '0;
    bus.p2_req = 1'b0;    bus.p2_wren = 1'b0;   bus.p2_addr = '0;  bus.p2_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", bus.p2_ready, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", bus.p2_rdata, 0);
    chk("rst_state", state_o, IDLE);

    // read miss then hit
    sb_begin();
    exp_q.push_back({1'b0, 17'h00C45, 16'hA9E0});
    access(7'd3, 10'h045, 1'b0, 16'h0, 1'b0, 1, rd, lat, pul);
    chk("t1_miss_rdata", rd, 16'hA9E0);
    chk("t1_miss_pulses", pul, 1);
    sb_check("t1_miss_mem");
    sb_begin();
    access(7'd3, 10'h045, 1'b0, 16'h0, 1'b0, 1, rd, lat, pul);
    chk("t1_hit_lat", lat, 2);
    chk("t1_hit_rdata", rd, 16'hA9E0);
    sb_check("t1_hit_mem");

    // clean write miss allocates, read back hits
    sb_begin();
    access(7'd0, 10'h010, 1'b1, 16'hBEEF, 1'b0, 1, rd, lat, pul);
    chk("t2_wr_lat", lat, 2);
    sb_check("t2_wr_mem");
    sb_begin();
    access(7'd0, 10'h010, 1'b0, 16'h0, 1'b0, 1, rd, lat, pul);
    chk("t2_rd_lat", lat, 2);
    chk("t2_rd_rdata", rd, 16'hBEEF);
    sb_check("t2_rd_mem");

    // dirty victim: write-back then fill
    sb_begin();
    exp_q.push_back({1'b1, 17'h00010, 16'hBEEF});
    exp_q.push_back({1'b0, 17'h00410, 16'hA1B5});
    access(7'd1, 10'h010, 1'b0, 16'h0, 1'b0, 1, rd, lat, pul);
    chk("t3_rdata", rd, 16'hA1B5);
    sb_check("t3_mem");

    // flush with dirty lines at index 2 and 40
    access(7'd2, 10'h002, 1'b1, 16'h1111, 1'b0, 1, rd, lat, pul);
    access(7'd4, 10'h068, 1'b1, 16'h2222, 1'b0, 1, rd, lat, pul);
    sb_begin();
    exp_q.push_back({1'b1, 17'h00802, 16'h1111});
    exp_q.push_back({1'b1, 17'h01068, 16'h2222});
    flush(bc);
    chk("t4_busy_ge_192", bc >= 192, 1);
    sb_check("t4_flush_mem");
    sb_begin();
    exp_q.push_back({1'b0, 17'h00802, 16'h1111});
    exp_q.push_back({1'b0, 17'h00410, 16'hA1B5});
    access(7'd2, 10'h002, 1'b0, 16'h0, 1'b0, 1, rd, lat, pul);
    chk("t4_refill_rdata", rd, 16'h1111);
    access(7'd1, 10'h010, 1'b0, 16'h0, 1'b0, 1, rd, lat, pul);
    chk("t4_clean_refill", rd, 16'hA1B5);
    sb_check("t4_refill_mem");

    // soft reset discards dirty data
    access(7'd5, 10'h123, 1'b1, 16'h7777, 1'b0, 1, rd, lat, pul);
    sb_begin();
    soft_reset();
    chk("t5_busy", busy, 0);
    exp_q.push_back({1'b0, 17'h01523, 16'hB086});
    access(7'd5, 10'h123, 1'b0, 16'h0, 1'b0, 1, rd, lat, pul);
    chk("t5_rdata", rd, 16'hB086);
    sb_check("t5_mem");

    // soft reset during a fill drops mem_req
    sb_begin();
    @(negedge clk);
    bus.p2_page = 7'd7;  bus.p2_addr = 10'h3FF;  bus.p2_wren = 1'b0;  bus.p2_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t5b_fill_req", bus.mem_req, 1);
    @(negedge clk);
    bus.p2_reset = 1'b1;
    bus.p2_req = 1'b0;
    @(posedge clk); #1;
    chk("t5b_req_dropped", bus.mem_req, 0);
    chk("t5b_idle", busy, 0);
    @(negedge clk);
    bus.p2_reset = 1'b0;
    repeat (3) @(negedge clk);
    sb_check("t5b_mem");

    // flush and request together: flush first, one ready for the held request
    sb_begin();
    exp_q.push_back({1'b0, 17'h01A00, 16'hBFA5});
    access(7'd6, 10'h200, 1'b0, 16'h0, 1'b1, 5, rd, lat, pul);
    chk("t6_pulses", pul, 1);
    chk("t6_rdata", rd, 16'hBFA5);
    chk("t6_after_flush", lat >= 192, 1);
    sb_check("t6_mem");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
